spi_slave_cu: RTL and testbench

SPI slave (responder) for the SPI master control unit. Full-duplex, 8-bit frames, all four CPOL/CPHA modes.
- Oversamples SCK, SS_n and MOSI in the system Clk domain.
- Shifts received bits into a byte register and delivers each byte to local logic with a one-cycle valid strobe.
- Drives MISO from a byte captured from local logic at each frame/byte start.
- Sits between the SPI pins and the local register or FIFO interface.

---
 rtl/spi_slave_cu.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_slave_cu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_cu.sv
// SPI slave control unit: oversampled SCK/SS_n/MOSI, 8-bit full-duplex frames, CPOL/CPHA modes 0..3.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first bit order (default MSB first).
module spi_slave_cu #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CPol,
    input  logic              CPha,
    input  logic              SCK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MisoOe,
    input  logic [DATA_W-1:0] TxData,
    output logic              TxAck,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        BYTE_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ssn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ssn_d;

    logic                   r_cpol;
    logic                   r_cpha;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_W-1:0]      r_rx_sr;
    logic [DATA_W-1:0]      r_tx_sr;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_miso;
    logic                   r_rx_valid;
    logic                   r_frame_err;

    logic                   w_sck;
    logic                   w_ssn;
    logic                   w_mosi;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift_edge;
    logic                   w_ssn_fall;
    logic                   w_last;
    logic                   w_tx_first;
    logic                   w_tx_sr_first;
    logic [DATA_W-1:0]      w_tx_load;
    logic [DATA_W-1:0]      w_tx_adv;
    logic [DATA_W-1:0]      w_rx_next;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sck_sync  <= '0;
            r_ssn_sync  <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ssn_d     <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sck_d     <= w_sck;
            r_ssn_d     <= w_ssn;
        end
    end

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_ssn  = r_ssn_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_ssn_fall = ~w_ssn & r_ssn_d;
    assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample   = r_cpha ? w_trail : w_lead;
    // CPha=0 with count 0 is the trailing edge after the previous byte's last sample: hold MISO
    assign w_shift_edge = r_cpha ? w_lead : (w_trail && (r_cnt != '0));
    assign w_last       = w_sample && (r_cnt == CNT_W'(DATA_W - 1));

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign w_tx_first    = TxData[0];
    assign w_tx_sr_first = r_tx_sr[0];
    assign w_tx_adv      = r_tx_sr >> 1;
    assign w_rx_next     = {w_mosi, r_rx_sr[DATA_W-1:1]};
    assign w_tx_load     = r_cpha ? TxData : (TxData >> 1);
`else
    assign w_tx_first    = TxData[DATA_W-1];
    assign w_tx_sr_first = r_tx_sr[DATA_W-1];
    assign w_tx_adv      = r_tx_sr << 1;
    assign w_rx_next     = {r_rx_sr[DATA_W-2:0], w_mosi};
    assign w_tx_load     = r_cpha ? TxData : (TxData << 1);
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_ssn_fall) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = SHIFT;
            end
            SHIFT: begin
                // A deselect seen in the same cycle as a sample edge discards that bit
                if (w_ssn) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = BYTE_DONE;
                end
            end
            BYTE_DONE: begin
                w_next = w_ssn ? IDLE : SHIFT;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_rx_data   <= '0;
            r_miso      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_miso <= 1'b0;
                    r_cnt  <= '0;
                    if (w_ssn_fall) begin
                        r_cpol <= CPol;
                        r_cpha <= CPha;
                    end
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_tx_sr <= w_tx_load;
                    if (!r_cpha) begin
                        r_miso <= w_tx_first;
                    end
                end
                SHIFT: begin
                    if (w_ssn) begin
                        r_miso      <= 1'b0;
                        r_frame_err <= (r_cnt != '0);
                    end else begin
                        if (w_sample) begin
                            r_rx_sr <= w_rx_next;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                        if (w_shift_edge) begin
                            r_miso  <= w_tx_sr_first;
                            r_tx_sr <= w_tx_adv;
                        end
                    end
                end
                BYTE_DONE: begin
                    r_rx_data  <= r_rx_sr;
                    r_rx_valid <= 1'b1;
                    r_cnt      <= '0;
                    if (w_ssn) begin
                        r_miso <= 1'b0;
                    end else begin
                        r_tx_sr <= w_tx_load;
                        if (!r_cpha) begin
                            r_miso <= w_tx_first;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        MisoOe   = (r_state != IDLE);
        Busy     = (r_state != IDLE);
        TxAck    = (r_state == LOAD) || ((r_state == BYTE_DONE) && !w_ssn);
        MISO     = r_miso;
        RxData   = r_rx_data;
        RxValid  = r_rx_valid;
        FrameErr = r_frame_err;
    end

endmodule

// File: tb/tb_spi_slave_cu.sv
// Self-checking bench for spi_slave_cu: bit-level SPI master model plus directed and random frames.
`timescale 1ns/1ps
module tb_spi_slave_cu;

    localparam int H = 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       CPol = 1'b0;
    logic       CPha = 1'b0;
    logic       SCK = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       MISO, MisoOe, TxAck, RxValid, FrameErr, Busy;
    logic [7:0] RxData;

    always #5 Clk = ~Clk;

    spi_slave_cu #(
        .SYNC_STAGES(2),
        .DATA_W     (8)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .CPol    (CPol),
        .CPha    (CPha),
        .SCK     (SCK),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MisoOe  (MisoOe),
        .TxData  (TxData),
        .TxAck   (TxAck),
        .RxData  (RxData),
        .RxValid (RxValid),
        .FrameErr(FrameErr),
        .Busy    (Busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int ack_cnt  = 0;
    int ferr_cnt = 0;
    logic [7:0] rx_q[$];

    logic [7:0] m_tx[4];
    logic [7:0] s_tx[4];
    logic [7:0] m_rx[4];

    always @(negedge Clk) begin
        if (RxValid) begin
            rxv_cnt++;
            rx_q.push_back(RxData);
        end
        if (TxAck)    ack_cnt++;
        if (FrameErr) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bidx(input int i);
        return LSB ? (i % 8) : (7 - (i % 8));
    endfunction

    function automatic logic mbit(input int i);
        logic [7:0] v;
        v = m_tx[i / 8];
        return v[bidx(i)];
    endfunction

    // ending: 0 clean (SS_n up 1 Clk after last sample), 1 SS_n up on the last sample edge,
    //         2 SS_n up after nbits full SCK cycles, 3 stay selected (caller resets)
    task automatic frame(input bit cpol, input bit cpha, input int nbytes, input int nbits,
                         input int ending, input string tag);
        int ack0, rxv0, ferr0, exp_bytes, exp_ack, exp_ferr;
        bit oe_bad, last;
        logic [7:0] rxd_before, exp_rxd;
        CPol   = cpol;
        CPha   = cpha;
        SCK    = cpol;
        TxData = s_tx[0];
        repeat (2 * H) @(negedge Clk);
        rx_q.delete();
        ack0 = ack_cnt; rxv0 = rxv_cnt; ferr0 = ferr_cnt;
        oe_bad = 1'b0;
        rxd_before = RxData;
        for (int b = 0; b < 4; b++) m_rx[b] = 8'h00;
        SS_n = 1'b0;
        MOSI = cpha ? 1'b0 : mbit(0);
        repeat (2 * H) @(negedge Clk);
        check({tag, "_ack_load"}, ack_cnt - ack0, 1);
        for (int i = 0; i < nbits; i++) begin
            last = (i == nbits - 1);
            if (!cpha) begin
                m_rx[i / 8][bidx(i)] = MISO;
                SCK = ~cpol;
                if (last && ending == 1) SS_n = 1'b1;
            end else begin
                SCK  = ~cpol;
                MOSI = mbit(i);
            end
            if ((i % 8 == 0) && (i / 8 + 1 < nbytes)) TxData = s_tx[i / 8 + 1];
            if (!MisoOe) oe_bad = 1'b1;
            if (last && !cpha && ending != 2) break;
            repeat (H) @(negedge Clk);
            if (!cpha) begin
                SCK = cpol;
                if (i + 1 < nbits) MOSI = mbit(i + 1);
            end else begin
                m_rx[i / 8][bidx(i)] = MISO;
                SCK = cpol;
                if (last && ending == 1) SS_n = 1'b1;
            end
            if (last && ending != 2) break;
            repeat (H) @(negedge Clk);
        end
        if (ending == 3) return;
        if (ending == 0) begin
            @(negedge Clk);
            SS_n = 1'b1;
        end
        if (ending == 2) begin
            SS_n = 1'b1;
            repeat (4) @(posedge Clk);
            #1;
            check({tag, "_busy_drop"}, Busy, 1'b0);
            @(negedge Clk);
        end
        repeat (H) @(negedge Clk);
        SCK  = cpol;
        MOSI = 1'b0;
        repeat (2 * H) @(negedge Clk);

        exp_bytes = (ending == 0) ? nbits / 8 : (nbits - 1) / 8;
        exp_ferr  = (ending == 0) ? 0 : 1;
        exp_ack   = 1 + ((ending == 0) ? exp_bytes - 1 : exp_bytes);
        exp_rxd   = (exp_bytes > 0) ? m_tx[exp_bytes - 1] : rxd_before;
        check({tag, "_idle_oe_busy_miso"}, {MisoOe, Busy, MISO}, 3'b000);
        check({tag, "_oe_while_sel"}, oe_bad, 1'b0);
        check({tag, "_frame_err"}, ferr_cnt - ferr0, exp_ferr);
        check({tag, "_rx_valid"}, rxv_cnt - rxv0, exp_bytes);
        check({tag, "_tx_ack"}, ack_cnt - ack0, exp_ack);
        check({tag, "_rxdata"}, RxData, exp_rxd);
        for (int b = 0; b < exp_bytes; b++) begin
            check({tag, "_slave_rx"}, (b < rx_q.size()) ? rx_q[b] : 8'hxx, m_tx[b]);
            check({tag, "_master_rx"}, m_rx[b], s_tx[b]);
        end
    endtask

    initial begin
        int nb, nbits, ending;
        bit cpol, cpha;

        repeat (3) @(negedge Clk);
        check("reset_outputs", {MISO, MisoOe, TxAck, RxData, RxValid, FrameErr, Busy}, 14'h0);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);

        m_tx[0] = 8'hA5; s_tx[0] = 8'h3C;
        frame(1'b0, 1'b0, 1, 8, 0, "mode0");

        m_tx[0] = 8'h81; s_tx[0] = 8'hF0;
        frame(1'b1, 1'b1, 1, 8, 0, "mode3");

        m_tx[0] = 8'h12; m_tx[1] = 8'h34;
        s_tx[0] = 8'($urandom); s_tx[1] = 8'h56;
        frame(1'b0, 1'b1, 2, 16, 0, "mode1_2byte");

        m_tx[0] = 8'($urandom); s_tx[0] = 8'($urandom);
        frame(1'b1, 1'b0, 1, 5, 2, "mode2_abort");

        m_tx[0] = 8'h6B; s_tx[0] = 8'h9E;
        frame(1'b0, 1'b0, 1, 8, 1, "simul_cpha0");
        frame(1'b0, 1'b1, 1, 8, 1, "simul_cpha1");

        m_tx[0] = 8'h77; s_tx[0] = 8'h11;
        frame(1'b0, 1'b0, 1, 8, 0, "pre_reset");
        m_tx[0] = 8'($urandom); s_tx[0] = 8'($urandom);
        frame(1'b0, 1'b0, 1, 3, 3, "rst_mid");
        repeat (4) @(negedge Clk);
        check("rst_mid_busy_pre", Busy, 1'b1);
        #2 Rst_n = 1'b0;
        #1 check("rst_mid_outputs", {MISO, MisoOe, TxAck, RxData, RxValid, FrameErr, Busy}, 14'h0);
        @(negedge Clk);
        SS_n = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        m_tx[0] = 8'h5A; s_tx[0] = 8'($urandom);
        frame(1'b0, 1'b0, 1, 8, 0, "after_reset");

`ifdef SPI_SLAVE_LSB_FIRST_EN
        m_tx[0] = 8'hC3; s_tx[0] = 8'h01;
        frame(1'b0, 1'b0, 1, 8, 0, "lsb_first");
`endif

        for (int f = 0; f < 20; f++) begin
            cpol   = 1'($urandom);
            cpha   = 1'($urandom);
            nb     = 1 + $urandom_range(0, 2);
            ending = ($urandom_range(0, 4) == 0) ? 2 : 0;
            nbits  = (ending == 2) ? 8 * (nb - 1) + $urandom_range(1, 7) : 8 * nb;
            for (int b = 0; b < 4; b++) begin
                m_tx[b] = 8'($urandom);
                s_tx[b] = 8'($urandom);
            end
            frame(cpol, cpha, nb, nbits, ending, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
